// File: rtl/request_conditioner_pkg.sv
// Shared constants and the request-vector type used along the
// button -> request -> priority_encoder path.
package request_conditioner_pkg;

  localparam int REQ_N          = 4;
  localparam int DEBOUNCE_SIM   = 16;
  localparam int DEBOUNCE_BOARD = 1_000_000;

  typedef logic [REQ_N-1:0] req_vec_t;

endpackage

// File: rtl/request_conditioner_debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter,
// debounced level and a registered rising-edge strobe.
module debounce_channel
  import request_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic pulse_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic             stable_d;
  logic             pulse_q;
  logic             pulse_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter runs only while s2 disagrees with the accepted level; any agreement restarts it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    pulse_d = stable_d & ~stable_q;
  end

  // Synchroniser, debounce state and strobe register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      s1_q     <= btn_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign level_o = stable_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/request_conditioner.sv
// Turns raw push-button levels into a sticky request vector for the
// priority encoder; the consumer clears the channel it has serviced.
module request_conditioner
  import request_conditioner_pkg::*;
#(
  parameter int N_REQ           = REQ_N,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] btn_in,
  input  logic [N_REQ-1:0] clear,
  output logic [N_REQ-1:0] level_o,
  output logic [N_REQ-1:0] pulse_o,
  output logic [N_REQ-1:0] req_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] req_d;

  for (genvar g = 0; g < N_REQ; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn_in[g]),
      .level_o(level_o[g]),
      .pulse_o(pulse_o[g])
    );
  end

  // A fresh rising edge takes priority over a coincident clear so no event is lost.
  always_comb begin
    req_d = (req_q & ~clear) | pulse_o;
  end

  // Request latch register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  assign req_o = req_q;

endmodule
